// File: rtl/conv1x1_pkg.sv
// Shared types and config helpers for the 1x1 convolution address sequencer.
// Config fields are carried at a fixed 32-bit width so helpers are independent of DIM_W.
package conv1x1_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned CFG_FIELD_W = 32;

  typedef struct packed {
    logic [CFG_FIELD_W-1:0] channels;
    logic [CFG_FIELD_W-1:0] filters;
    logic [CFG_FIELD_W-1:0] pixels;
  } cfg_t;

  function automatic logic cfg_valid(input cfg_t cfg, input int unsigned lane);
    return (cfg.channels != 0) && ((cfg.channels % lane) == 0) &&
           (cfg.filters != 0) && (cfg.pixels != 0);
  endfunction

  // Groups of num_pe filters, rounded up; only meaningful for filters >= 1.
  function automatic logic [CFG_FIELD_W-1:0] group_count(input cfg_t cfg, input int unsigned num_pe);
    return ((cfg.filters - 1) / num_pe) + 1;
  endfunction

  // Low-bit mask of the PEs that hold a real filter in the final group.
  function automatic logic [63:0] last_group_mask(input cfg_t cfg, input int unsigned num_pe);
    logic [CFG_FIELD_W-1:0] n_active;
    n_active = ((cfg.filters - 1) % num_pe) + 1;
    return (64'd1 << n_active) - 64'd1;
  endfunction

endpackage

// File: rtl/conv1x1_addr_gen_if.sv
// Fetch-beat bus between the address sequencer and the IFM/weight fetch unit.
interface conv1x1_addr_gen_if #(
  parameter int unsigned NUM_PE = 4,
  parameter int unsigned ADDR_W = 32
);
  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] addr_ifm;
  logic [ADDR_W-1:0] addr_weight;
  logic              pe_clear;
  logic              pe_last;
  logic [NUM_PE-1:0] pe_mask;

  modport master (
    output addr_valid, addr_ifm, addr_weight, pe_clear, pe_last, pe_mask,
    input  addr_ready
  );

  modport slave (
    input  addr_valid, addr_ifm, addr_weight, pe_clear, pe_last, pe_mask,
    output addr_ready
  );
endinterface

// File: rtl/conv1x1_loop_cnt.sv
// Nested chunk (inner) / group / pixel (outer) counter with wrap flags.
// Each level wraps to zero after reaching its programmed maximum index.
module conv1x1_loop_cnt #(
  parameter int unsigned DIM_W = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_adv,
  input  logic [DIM_W-1:0] i_chunk_max,
  input  logic [DIM_W-1:0] i_group_max,
  input  logic [DIM_W-1:0] i_pixel_max,
  output logic             o_chunk_first,
  output logic             o_chunk_last,
  output logic             o_group_last,
  output logic             o_final
);

  logic [DIM_W-1:0] r_chunk;
  logic [DIM_W-1:0] r_group;
  logic [DIM_W-1:0] r_pixel;
  logic             w_pixel_last;

  assign o_chunk_first = (r_chunk == '0);
  assign o_chunk_last  = (r_chunk == i_chunk_max);
  assign o_group_last  = (r_group == i_group_max);
  assign w_pixel_last  = (r_pixel == i_pixel_max);
  assign o_final       = o_chunk_last && o_group_last && w_pixel_last;

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chunk <= '0;
      r_group <= '0;
      r_pixel <= '0;
    end else if (i_clear) begin
      r_chunk <= '0;
      r_group <= '0;
      r_pixel <= '0;
    end else if (i_adv) begin
      if (!o_chunk_last) begin
        r_chunk <= r_chunk + DIM_W'(1);
      end else begin
        r_chunk <= '0;
        if (!o_group_last) begin
          r_group <= r_group + DIM_W'(1);
        end else begin
          r_group <= '0;
          r_pixel <= w_pixel_last ? '0 : r_pixel + DIM_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/conv1x1_addr_gen.sv
// 1x1 convolution fetch sequencer: walks pixel / filter group / channel chunk,
// issuing IFM and weight addresses with PE clear/last/mask over a valid/ready bus.
module conv1x1_addr_gen
  import conv1x1_pkg::*;
#(
  parameter int unsigned NUM_PE    = 4,
  parameter int unsigned LANE      = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DIM_W     = 12,
  parameter int unsigned DRAIN_CYC = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DIM_W-1:0]      cfg_channels,
  input  logic [DIM_W-1:0]      cfg_filters,
  input  logic [DIM_W-1:0]      cfg_pixels,
  conv1x1_addr_gen_if.master    fetch,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  localparam int unsigned LANE_SH    = $clog2(LANE);
  localparam int unsigned PE_SH      = $clog2(NUM_PE);
  localparam int unsigned DRAIN_W    = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;
  // DRAIN lasts DRAIN_CYC-1 cycles; the done cycle itself completes the count.
  localparam int unsigned DRAIN_LAST = (DRAIN_CYC >= 2) ? DRAIN_CYC - 2 : 0;
  localparam logic [ADDR_W-1:0] LANE_A = ADDR_W'(LANE);
  localparam logic [NUM_PE-1:0] ALL_PE = '1;

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_done;
  logic                r_cfg_err;
  logic                w_done_nxt;
  logic                w_err_nxt;
  logic                w_load;
  logic                w_adv;
  logic [DRAIN_W-1:0]  r_drain_cnt;

  cfg_t                w_cfg;
  logic [DIM_W-1:0]    r_chunk_max;
  logic [DIM_W-1:0]    r_group_max;
  logic [DIM_W-1:0]    r_pixel_max;
  logic [NUM_PE-1:0]   r_last_mask;
  logic [ADDR_W-1:0]   r_rewind;
  logic [ADDR_W-1:0]   r_grp_step;
  logic [ADDR_W-1:0]   r_ifm;
  logic [ADDR_W-1:0]   r_wgt;

  logic                w_run;
  logic                w_chunk_first;
  logic                w_chunk_last;
  logic                w_group_last;
  logic                w_final;

  assign w_cfg = '{channels: CFG_FIELD_W'(cfg_channels),
                   filters:  CFG_FIELD_W'(cfg_filters),
                   pixels:   CFG_FIELD_W'(cfg_pixels)};

  assign w_run = (r_state == RUN);

  conv1x1_loop_cnt #(
    .DIM_W (DIM_W)
  ) u_loop_cnt (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_clear       (w_load),
    .i_adv         (w_adv),
    .i_chunk_max   (r_chunk_max),
    .i_group_max   (r_group_max),
    .i_pixel_max   (r_pixel_max),
    .o_chunk_first (w_chunk_first),
    .o_chunk_last  (w_chunk_last),
    .o_group_last  (w_group_last),
    .o_final       (w_final)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    if (abort) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            if (cfg_valid(w_cfg, LANE)) begin
              w_load      = 1'b1;
              w_state_nxt = RUN;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
        end
        RUN: begin
          if (fetch.addr_ready) begin
            w_adv = 1'b1;
            if (w_final) begin
              if (DRAIN_CYC <= 1) begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
              end else begin
                w_state_nxt = DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (r_drain_cnt == DRAIN_W'(DRAIN_LAST)) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_done      <= w_done_nxt;
      r_cfg_err   <= w_err_nxt;
      r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + DRAIN_W'(1) : '0;
    end
  end

  // Config derived once at start so the run loop needs only compares and adds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chunk_max <= '0;
      r_group_max <= '0;
      r_pixel_max <= '0;
      r_last_mask <= '0;
      r_rewind    <= '0;
      r_grp_step  <= '0;
    end else if (w_load) begin
      r_chunk_max <= (cfg_channels >> LANE_SH) - DIM_W'(1);
      r_group_max <= DIM_W'(group_count(w_cfg, NUM_PE) - CFG_FIELD_W'(1));
      r_pixel_max <= cfg_pixels - DIM_W'(1);
      r_last_mask <= NUM_PE'(last_group_mask(w_cfg, NUM_PE));
      r_rewind    <= ADDR_W'(cfg_channels) - LANE_A;
      r_grp_step  <= ADDR_W'(cfg_channels) << PE_SH;
    end
  end

  // Running address adders. Chunk wrap rewinds IFM to the pixel base and steps
  // the weight base one group; group wrap lands IFM exactly on the next pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ifm <= '0;
      r_wgt <= '0;
    end else if (w_load) begin
      r_ifm <= '0;
      r_wgt <= '0;
    end else if (w_adv) begin
      if (!w_chunk_last) begin
        r_ifm <= r_ifm + LANE_A;
        r_wgt <= r_wgt + LANE_A;
      end else if (!w_group_last) begin
        r_ifm <= r_ifm - r_rewind;
        r_wgt <= r_wgt - r_rewind + r_grp_step;
      end else begin
        r_ifm <= r_ifm + LANE_A;
        r_wgt <= '0;
      end
    end
  end

  assign fetch.addr_valid  = w_run;
  assign fetch.addr_ifm    = r_ifm;
  assign fetch.addr_weight = r_wgt;
  assign fetch.pe_clear    = w_run && w_chunk_first;
  assign fetch.pe_last     = w_run && w_chunk_last;
  assign fetch.pe_mask     = w_run ? (w_group_last ? r_last_mask : ALL_PE) : '0;

  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_conv1x1_addr_gen.sv
// Self-checking bench for conv1x1_addr_gen: table-driven runs plus corner sequences,
// compared against a nested-loop arithmetic model of the fetch order.
module tb_conv1x1_addr_gen;

  localparam int unsigned NUM_PE    = 4;
  localparam int unsigned LANE      = 4;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DIM_W     = 12;
  localparam int unsigned DRAIN_CYC = 6;
  localparam int          BUDGET    = 4000;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] ifm;
    logic [ADDR_W-1:0] wgt;
    logic              clr;
    logic              lst;
    logic [NUM_PE-1:0] mask;
  } beat_t;

  typedef struct {
    int c;
    int f;
    int p;
    bit exp_err;
    int exp_beats;
    int mode;   // 0: ready high, 1: ready 1,0,0,1 pattern, 2: random ready
  } vec_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic             abort;
  logic [DIM_W-1:0] cfg_channels;
  logic [DIM_W-1:0] cfg_filters;
  logic [DIM_W-1:0] cfg_pixels;
  logic             busy;
  logic             done;
  logic             cfg_err;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t exp_q[$];
  beat_t got_q[$];
  int    pat[4] = '{1, 0, 0, 1};
  vec_t  vecs[10];

  conv1x1_addr_gen_if #(.NUM_PE(NUM_PE), .ADDR_W(ADDR_W)) fetch_if ();

  conv1x1_addr_gen #(
    .NUM_PE    (NUM_PE),
    .LANE      (LANE),
    .ADDR_W    (ADDR_W),
    .DIM_W     (DIM_W),
    .DRAIN_CYC (DRAIN_CYC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .cfg_channels (cfg_channels),
    .cfg_filters  (cfg_filters),
    .cfg_pixels   (cfg_pixels),
    .fetch        (fetch_if),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t sample();
    beat_t b;
    b.valid = fetch_if.addr_valid;
    b.ifm   = fetch_if.addr_ifm;
    b.wgt   = fetch_if.addr_weight;
    b.clr   = fetch_if.pe_clear;
    b.lst   = fetch_if.pe_last;
    b.mask  = fetch_if.pe_mask;
    return b;
  endfunction

  // Reference order: pixel outer, filter group, channel chunk inner.
  task automatic build_model(input int c, input int f, input int p);
    int n_grp;
    int n_chk;
    int active;
    beat_t b;
    n_grp = (f + NUM_PE - 1) / NUM_PE;
    n_chk = c / LANE;
    exp_q.delete();
    for (int pi = 0; pi < p; pi++)
      for (int gi = 0; gi < n_grp; gi++)
        for (int ci = 0; ci < n_chk; ci++) begin
          active  = (gi == n_grp - 1) ? f - gi * NUM_PE : NUM_PE;
          b.valid = 1'b1;
          b.ifm   = ADDR_W'(pi * c + ci * LANE);
          b.wgt   = ADDR_W'(gi * NUM_PE * c + ci * LANE);
          b.clr   = (ci == 0);
          b.lst   = (ci == n_chk - 1);
          b.mask  = NUM_PE'((1 << active) - 1);
          exp_q.push_back(b);
        end
  endtask

  task automatic pulse_start(input int c, input int f, input int p);
    cfg_channels = DIM_W'(c);
    cfg_filters  = DIM_W'(f);
    cfg_pixels   = DIM_W'(p);
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic run_job(input int c, input int f, input int p, input int mode,
                         input string tag, input bit poke_start, output int n_beats);
    int    idx       = 0;
    int    last_acc  = -1;
    int    done_cyc  = -1;
    bit    prev_stall = 1'b0;
    bit    err_seen  = 1'b0;
    bit    busy_drop = 1'b0;
    logic  busy_at_done = 1'b1;
    beat_t prev;
    build_model(c, f, p);
    got_q.delete();
    pulse_start(c, f, p);
    check({tag, " first valid"}, fetch_if.addr_valid, 1);
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      beat_t cur;
      logic  rdy;
      cur = sample();
      if (cfg_err) err_seen = 1'b1;
      if (done) begin
        done_cyc     = cyc;
        busy_at_done = busy;
        break;
      end
      if (!busy) busy_drop = 1'b1;
      if (prev_stall)
        check($sformatf("%s stall hold cyc%0d", tag, cyc), cur, prev);
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4][0] : 1'($urandom_range(0, 1));
      fetch_if.addr_ready = rdy;
      if (cur.valid && rdy) begin
        if (idx < exp_q.size())
          check($sformatf("%s beat%0d", tag, idx), cur, exp_q[idx]);
        else
          check($sformatf("%s extra beat", tag), idx, exp_q.size());
        got_q.push_back(cur);
        idx++;
        last_acc = cyc;
      end
      prev_stall = cur.valid && !rdy;
      prev       = cur;
      start      = 1'b0;
      if (poke_start && (cyc == 2 || (idx == exp_q.size() && cyc == last_acc + 2))) begin
        cfg_channels = DIM_W'(4);
        cfg_filters  = DIM_W'(1);
        cfg_pixels   = DIM_W'(1);
        start        = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    check({tag, " done seen"}, done_cyc >= 0, 1);
    check({tag, " beat count"}, idx, exp_q.size());
    check({tag, " drain latency"}, done_cyc - last_acc, DRAIN_CYC);
    check({tag, " busy low at done"}, busy_at_done, 0);
    check({tag, " busy during run"}, busy_drop, 0);
    check({tag, " no cfg_err"}, err_seen, 0);
    tick();
    check({tag, " done/valid after"}, {done, fetch_if.addr_valid, busy}, 3'b000);
    n_beats = idx;
  endtask

  task automatic err_case(input int c, input int f, input int p, input string tag);
    bit any_valid = 1'b0;
    pulse_start(c, f, p);
    check({tag, " cfg_err pulse"}, {cfg_err, busy, fetch_if.addr_valid}, 3'b100);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) check({tag, " cfg_err one cycle"}, cfg_err, 0);
      if (fetch_if.addr_valid || busy) any_valid = 1'b1;
    end
    check({tag, " stays idle"}, any_valid, 0);
  endtask

  initial begin
    int    nb;
    int    exp_ifm1[8] = '{0, 4, 0, 4, 8, 12, 8, 12};
    int    exp_wgt1[8] = '{0, 4, 32, 36, 0, 4, 32, 36};
    bit    done_seen;
    beat_t cur;

    vecs[0] = '{8, 8, 2, 1'b0, 8, 0};
    vecs[1] = '{4, 6, 1, 1'b0, 2, 0};
    vecs[2] = '{8, 8, 2, 1'b0, 8, 1};
    vecs[3] = '{6, 4, 1, 1'b1, 0, 0};
    vecs[4] = '{8, 0, 1, 1'b1, 0, 0};
    vecs[5] = '{8, 4, 0, 1'b1, 0, 0};
    vecs[6] = '{0, 4, 1, 1'b1, 0, 0};
    vecs[7] = '{16, 5, 3, 1'b0, 24, 2};
    vecs[8] = '{12, 9, 2, 1'b0, 18, 2};
    vecs[9] = '{4, 1, 1, 1'b0, 1, 1};

    reset_n             = 1'b0;
    start               = 1'b0;
    abort               = 1'b0;
    cfg_channels        = '0;
    cfg_filters         = '0;
    cfg_pixels          = '0;
    fetch_if.addr_ready = 1'b1;
    repeat (2) tick();
    cur = sample();
    check("reset outputs", {cur, busy, done, cfg_err}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].exp_err) begin
        err_case(vecs[i].c, vecs[i].f, vecs[i].p, $sformatf("vec%0d", i));
      end else begin
        run_job(vecs[i].c, vecs[i].f, vecs[i].p, vecs[i].mode, $sformatf("vec%0d", i), 1'b0, nb);
        check($sformatf("vec%0d table beats", i), nb, vecs[i].exp_beats);
      end
    end

    // Literal address/flag sequence for C=8, F=8, P=2.
    run_job(8, 8, 2, 0, "lit8", 1'b0, nb);
    for (int i = 0; i < 8; i++) begin
      if (i < got_q.size()) begin
        check($sformatf("lit8 ifm%0d", i), got_q[i].ifm, exp_ifm1[i]);
        check($sformatf("lit8 wgt%0d", i), got_q[i].wgt, exp_wgt1[i]);
        check($sformatf("lit8 clr/lst%0d", i), {got_q[i].clr, got_q[i].lst},
              (i % 2 == 0) ? 2'b10 : 2'b01);
      end
    end

    // Partial final group: C=4, F=6, P=1.
    run_job(4, 6, 1, 0, "part", 1'b0, nb);
    if (got_q.size() == 2) begin
      check("part beat0", {got_q[0].mask, got_q[0].wgt, got_q[0].clr, got_q[0].lst},
            {4'b1111, 32'd0, 2'b11});
      check("part beat1", {got_q[1].mask, got_q[1].wgt, got_q[1].clr, got_q[1].lst},
            {4'b0011, 32'd16, 2'b11});
    end

    // start pulses (with altered config) during RUN and DRAIN must be ignored.
    run_job(8, 7, 2, 0, "poke", 1'b1, nb);

    // Abort while the third beat is presented, then restart from zero.
    fetch_if.addr_ready = 1'b1;
    pulse_start(16, 8, 4);
    for (int i = 0; i < 2; i++) tick();
    cur = sample();
    check("abort 3rd beat addr", {cur.valid, cur.ifm, cur.wgt}, {1'b1, 32'd8, 32'd8});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort idle next cycle", {fetch_if.addr_valid, busy, done}, 3'b000);
    done_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || fetch_if.addr_valid) done_seen = 1'b1;
    end
    check("abort no done", done_seen, 0);
    run_job(16, 8, 1, 0, "restart", 1'b0, nb);
    if (got_q.size() > 0)
      check("restart first addr", {got_q[0].ifm, got_q[0].wgt}, 64'd0);

    // Randomized configs with random ready.
    for (int r = 0; r < 4; r++) begin
      int c;
      int f;
      int p;
      c = LANE * $urandom_range(1, 4);
      f = $urandom_range(1, 9);
      p = $urandom_range(1, 3);
      run_job(c, f, p, 2, $sformatf("rnd%0d", r), (r % 2 == 1), nb);
    end

    // Asynchronous reset in the middle of a run.
    fetch_if.addr_ready = 1'b1;
    pulse_start(8, 8, 4);
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    #1;
    cur = sample();
    check("async reset outputs", {cur, busy, done, cfg_err}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("after reset idle", {fetch_if.addr_valid, busy}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
